udp_rx_chksum_input_ctrl: RTL and testbench
===========================================

UDP_RX_CHKSUM_INPUT_CTRL -- requirements
Module: udp_rx_chksum_input_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 256, SHALL set the width of the input data bus and the output tdata bus.
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8, SHALL set the width of the output tkeep bus.
REQ-003 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 src_udp_rx_hdr_val  in  1  IP-layer header valid.
REQ-006 src_udp_rx_src_ip, src_udp_rx_dst_ip  in  IP_ADDR_W each  IP source/destination addresses.
REQ-007 src_udp_rx_udp_len  in  TOT_LEN_W  UDP length in bytes (UDP header + payload), minimum 8.
REQ-008 src_udp_rx_timestamp  in  tracker_stats_struct  per-packet stats.
REQ-009 udp_rx_src_hdr_rdy  out  1  header accept.
REQ-010 src_udp_rx_data_val, src_udp_rx_data (MAC_INTERFACE_W), src_udp_rx_last, src_udp_rx_padbytes (MAC_PADBYTES_W)  in  stream of UDP header+payload, MSB-first.
REQ-011 udp_rx_src_data_rdy  out  1  data accept.
REQ-012 req_tval, req_tdata (DATA_WIDTH), req_tkeep (KEEP_WIDTH), req_tlast, req_tuser (tracker_stats_struct)  out  stream to checksum engine; req_trdy  in  1.

Function
REQ-013 FSM states SHALL be IDLE, FIRST, BODY, FLUSH.
REQ-014 IDLE: hdr_rdy=1; data_rdy=0; req_tval=0; on hdr_val, register addresses, udp_len, and timestamp; go to FIRST.
REQ-015 Pseudo header (12B) SHALL be {src_ip, dst_ip, 8'h0, 8'd17, udp_len[15:0]}, placed in req_tdata[255:160] of the first output line.
REQ-016 FIRST: req_tdata = {pseudo, data[255:96]}; req_tval = data_val; data_rdy = req_trdy (combinational pass-through, zero-cycle latency from data).
REQ-017 BODY: req_tdata = {hold_reg[95:0], data[255:96]}; same handshake as FIRST.
REQ-018 On every accepted data beat, hold_reg SHALL load data[95:0].
REQ-019 r = 32 - padbytes on the last input beat; if r <= 20, the output line for that beat SHALL assert tlast, and the next state SHALL be IDLE.
REQ-020 If last and r > 20, the output line SHALL be full with tlast=0; the next state SHALL be FLUSH.
REQ-021 A non-last accept in FIRST or BODY SHALL go to BODY, with tkeep all-ones.
REQ-022 FLUSH: req_tval=1; data_rdy=0; req_tdata = {hold_reg, 160'h0}; tlast=1; valid bytes r-20; on req_trdy, go to IDLE.
REQ-023 tkeep SHALL mark N valid bytes from the MSB end: bits [KEEP_WIDTH-1 -: N].
REQ-024 On the last line, N SHALL be 12+r in FIRST or BODY, and r-20 in FLUSH.
REQ-025 req_tuser SHALL equal the registered timestamp on every beat of the packet.
REQ-026 hdr_rdy SHALL be 0 outside IDLE; the next header SHALL be accepted no earlier than the cycle after tlast handshake.
REQ-027 While req_tval=1 and req_trdy=0, req_tdata, req_tkeep, and req_tlast SHALL remain stable, provided the input holds stable.

Reset
REQ-028 rst SHALL force IDLE and clear hold_reg and the header registers.
REQ-029 Outputs after reset SHALL be hdr_rdy=1, data_rdy=0, req_tval=0.
REQ-030 Reset mid-packet SHALL discard the packet with no further output beats.

Structure
REQ-031 CHKSUM_PSEUDO_HDR_BYTES, UDP_HDR_BYTES, and chksum_pseudo_hdr SHALL come from packet_struct_pkg.
REQ-032 tracker_stats_struct SHALL come from tracker_pkg.
REQ-033 USE_BYTES=20, HOLD_BYTES=12 SHALL be derived localparams.
REQ-034 There SHALL be no sub-module; the keep mask SHALL be a local function.

Verification
REQ-035 udp_len=8, one beat with padbytes=24 -> one output: pseudo+UDP hdr, tkeep top 20 bits set, tlast=1.
REQ-036 udp_len=24, padbytes=8 -> two outputs: full line with tlast=0, then FLUSH line with tkeep top 4 bits set and tlast=1.
REQ-037 udp_len=40, two beats (second beat padbytes=24) -> output 1 full, output 2 {hold, 8B} with tkeep top 20 bits set and tlast=1.
REQ-038 req_trdy low 3 cycles mid-packet -> data_rdy=0, req_tdata stable, no beat lost or duplicated.
REQ-039 Back-to-back packets with hdr_val held high -> second header accepted the cycle after the first tlast handshake; tuser switches per packet.
REQ-040 rst asserted in BODY -> next cycle req_tval=0 and hdr_rdy=1.

Source files
------------

// File: rtl/udp_rx_chksum_input_ctrl_pkg.sv
// Shared types and constants for the UDP receive checksum input controller.
// Tracker stats, packet structures and the controller's own FSM encoding.
package tracker_pkg;
    typedef struct packed {
        logic [63:0] timestamp;
        logic [31:0] pkt_id;
    } tracker_stats_struct;
endpackage

package packet_struct_pkg;
    localparam int IP_ADDR_W               = 32;
    localparam int TOT_LEN_W               = 16;
    localparam int CHKSUM_PSEUDO_HDR_BYTES = 12;
    localparam int UDP_HDR_BYTES           = 8;
    localparam logic [7:0] IP_PROTO_UDP    = 8'd17;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [7:0]  zeros;
        logic [7:0]  protocol;
        logic [15:0] length;
    } chksum_pseudo_hdr;
endpackage

package udp_rx_chksum_input_ctrl_pkg;
    localparam int MAC_INTERFACE_W = 256;
    localparam int MAC_PADBYTES_W  = $clog2(MAC_INTERFACE_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_BODY  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;
endpackage

// File: rtl/udp_rx_chksum_input_ctrl_if.sv
// Header, payload and checksum-request streams of the UDP RX checksum input stage.
// slave = the controller, master = whatever drives headers/data and sinks requests.
interface udp_rx_chksum_input_ctrl_if #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int PAD_W      = $clog2(DATA_WIDTH / 8)
);
    import tracker_pkg::*;
    import packet_struct_pkg::*;

    logic                    src_udp_rx_hdr_val;
    logic [IP_ADDR_W-1:0]    src_udp_rx_src_ip;
    logic [IP_ADDR_W-1:0]    src_udp_rx_dst_ip;
    logic [TOT_LEN_W-1:0]    src_udp_rx_udp_len;
    tracker_stats_struct     src_udp_rx_timestamp;
    logic                    udp_rx_src_hdr_rdy;

    logic                    src_udp_rx_data_val;
    logic [DATA_WIDTH-1:0]   src_udp_rx_data;
    logic                    src_udp_rx_last;
    logic [PAD_W-1:0]        src_udp_rx_padbytes;
    logic                    udp_rx_src_data_rdy;

    logic                    req_tval;
    logic [DATA_WIDTH-1:0]   req_tdata;
    logic [KEEP_WIDTH-1:0]   req_tkeep;
    logic                    req_tlast;
    tracker_stats_struct     req_tuser;
    logic                    req_trdy;

    modport master (
        output src_udp_rx_hdr_val, src_udp_rx_src_ip, src_udp_rx_dst_ip,
               src_udp_rx_udp_len, src_udp_rx_timestamp,
               src_udp_rx_data_val, src_udp_rx_data, src_udp_rx_last,
               src_udp_rx_padbytes, req_trdy,
        input  udp_rx_src_hdr_rdy, udp_rx_src_data_rdy,
               req_tval, req_tdata, req_tkeep, req_tlast, req_tuser
    );

    modport slave (
        input  src_udp_rx_hdr_val, src_udp_rx_src_ip, src_udp_rx_dst_ip,
               src_udp_rx_udp_len, src_udp_rx_timestamp,
               src_udp_rx_data_val, src_udp_rx_data, src_udp_rx_last,
               src_udp_rx_padbytes, req_trdy,
        output udp_rx_src_hdr_rdy, udp_rx_src_data_rdy,
               req_tval, req_tdata, req_tkeep, req_tlast, req_tuser
    );
endinterface

// File: rtl/udp_rx_chksum_input_ctrl.sv
// Prepends the 12-byte UDP pseudo header to the UDP header+payload stream,
// realigning every line by 12 bytes for the downstream checksum engine.
module udp_rx_chksum_input_ctrl
    import tracker_pkg::*;
    import packet_struct_pkg::*;
    import udp_rx_chksum_input_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input logic                      clk,
    input logic                      rst,
    udp_rx_chksum_input_ctrl_if.slave io_bus
);
    localparam int LINE_BYTES = DATA_WIDTH / 8;
    localparam int HOLD_BYTES = CHKSUM_PSEUDO_HDR_BYTES;
    localparam int USE_BYTES  = LINE_BYTES - HOLD_BYTES;
    localparam int HOLD_W     = HOLD_BYTES * 8;
    localparam int USE_W      = USE_BYTES * 8;
    localparam int PAD_W      = $clog2(KEEP_WIDTH);
    localparam int CNT_W      = PAD_W + 1;

    function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [CNT_W-1:0] n);
        logic [KEEP_WIDTH-1:0] m;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            m[KEEP_WIDTH-1-i] = (i < int'(n));
        end
        return m;
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [IP_ADDR_W-1:0]  r_src_ip;
    logic [IP_ADDR_W-1:0]  r_dst_ip;
    logic [TOT_LEN_W-1:0]  r_udp_len;
    tracker_stats_struct   r_tuser;
    logic [HOLD_W-1:0]     r_hold;
    logic [CNT_W-1:0]      r_flush_n;

    logic                  w_hdr_acc;
    logic                  w_dat_acc;
    logic [CNT_W-1:0]      w_rem;
    logic                  w_short;
    logic [USE_W-1:0]      w_data_hi;
    chksum_pseudo_hdr      w_pseudo;

    assign w_rem     = CNT_W'(LINE_BYTES) - CNT_W'(io_bus.src_udp_rx_padbytes);
    assign w_short   = (w_rem <= CNT_W'(USE_BYTES));
    assign w_data_hi = io_bus.src_udp_rx_data[DATA_WIDTH-1 -: USE_W];

    always_comb begin
        w_pseudo          = '0;
        w_pseudo.src_ip   = r_src_ip;
        w_pseudo.dst_ip   = r_dst_ip;
        w_pseudo.protocol = IP_PROTO_UDP;
        w_pseudo.length   = r_udp_len[15:0];
    end

    assign io_bus.req_tuser = r_tuser;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next                     = r_state;
        w_hdr_acc                  = 1'b0;
        w_dat_acc                  = 1'b0;
        io_bus.udp_rx_src_hdr_rdy  = 1'b0;
        io_bus.udp_rx_src_data_rdy = 1'b0;
        io_bus.req_tval            = 1'b0;
        io_bus.req_tdata           = {w_pseudo, w_data_hi};
        io_bus.req_tkeep           = '1;
        io_bus.req_tlast           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                io_bus.udp_rx_src_hdr_rdy = 1'b1;
                if (io_bus.src_udp_rx_hdr_val) begin
                    w_hdr_acc = 1'b1;
                    w_next    = ST_FIRST;
                end
            end
            ST_FIRST, ST_BODY: begin
                io_bus.req_tval            = io_bus.src_udp_rx_data_val;
                io_bus.udp_rx_src_data_rdy = io_bus.req_trdy;
                if (r_state == ST_BODY) begin
                    io_bus.req_tdata = {r_hold, w_data_hi};
                end
                // A short last beat fits after the 12 carried bytes; a long one spills into FLUSH.
                if (io_bus.src_udp_rx_last && w_short) begin
                    io_bus.req_tlast = 1'b1;
                    io_bus.req_tkeep = keep_mask(CNT_W'(HOLD_BYTES) + w_rem);
                end
                if (io_bus.src_udp_rx_data_val && io_bus.req_trdy) begin
                    w_dat_acc = 1'b1;
                    if (!io_bus.src_udp_rx_last) begin
                        w_next = ST_BODY;
                    end else if (w_short) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                io_bus.req_tval  = 1'b1;
                io_bus.req_tdata = {r_hold, {USE_W{1'b0}}};
                io_bus.req_tlast = 1'b1;
                io_bus.req_tkeep = keep_mask(r_flush_n);
                if (io_bus.req_trdy) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_ip  <= '0;
            r_dst_ip  <= '0;
            r_udp_len <= '0;
            r_tuser   <= '0;
            r_hold    <= '0;
            r_flush_n <= '0;
        end else begin
            if (w_hdr_acc) begin
                r_src_ip  <= io_bus.src_udp_rx_src_ip;
                r_dst_ip  <= io_bus.src_udp_rx_dst_ip;
                r_udp_len <= io_bus.src_udp_rx_udp_len;
                r_tuser   <= io_bus.src_udp_rx_timestamp;
            end
            if (w_dat_acc) begin
                r_hold <= io_bus.src_udp_rx_data[HOLD_W-1:0];
                if (io_bus.src_udp_rx_last) begin
                    r_flush_n <= w_rem - CNT_W'(USE_BYTES);
                end
            end
        end
    end
endmodule

// File: tb/tb_udp_rx_chksum_input_ctrl.sv
// Bench for udp_rx_chksum_input_ctrl: packets are modelled as byte streams
// (pseudo header followed by UDP bytes) cut into 32-byte output lines.
module tb_udp_rx_chksum_input_ctrl;
    import tracker_pkg::*;
    import packet_struct_pkg::*;

    localparam int DW   = 256;
    localparam int KW   = DW / 8;
    localparam int MAXP = 24;
    localparam int MAXB = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udp_rx_chksum_input_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    udp_rx_chksum_input_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic [31:0]         src;
        logic [31:0]         dst;
        int                  len;
        tracker_stats_struct ts;
    } pkt_t;

    typedef struct {
        logic [DW-1:0]       data;
        logic [KW-1:0]       keep;
        logic                last;
        tracker_stats_struct user;
    } line_t;

    pkt_t       pk [MAXP];
    logic [7:0] pb [MAXP][MAXB];
    line_t      expq[$];
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic make_pkt(input int k, input int len);
        pk[k].src = $urandom;
        pk[k].dst = $urandom;
        pk[k].len = len;
        pk[k].ts  = tracker_stats_struct'({$urandom, $urandom, $urandom});
        for (int b = 0; b < MAXB; b++) pb[k][b] = 8'($urandom);
    endtask

    function automatic int nbeats(input int k);
        return (pk[k].len + 31) / 32;
    endfunction

    // Byte idx of the checksum stream: 12 pseudo-header bytes, then the UDP bytes.
    function automatic logic [7:0] stream_byte(input int k, input int idx);
        logic [95:0] ph;
        ph = {pk[k].src, pk[k].dst, 8'h00, 8'd17, 16'(pk[k].len)};
        if (idx < 12) return ph[95-8*idx -: 8];
        if (idx - 12 < pk[k].len) return pb[k][idx-12];
        return 8'h00;
    endfunction

    task automatic build_exp(input int n);
        line_t l;
        int    tot;
        int    nl;
        expq.delete();
        for (int k = 0; k < n; k++) begin
            tot = 12 + pk[k].len;
            nl  = (tot + 31) / 32;
            for (int j = 0; j < nl; j++) begin
                for (int b = 0; b < 32; b++) begin
                    l.data[DW-1-8*b -: 8] = (32*j + b < tot) ? stream_byte(k, 32*j + b) : 8'h00;
                    l.keep[KW-1-b]        = (32*j + b < tot);
                end
                l.last = (j == nl - 1);
                l.user = pk[k].ts;
                expq.push_back(l);
            end
        end
    endtask

    task automatic drive_hdr(input int k);
        bus.src_udp_rx_hdr_val   = 1'b1;
        bus.src_udp_rx_src_ip    = pk[k].src;
        bus.src_udp_rx_dst_ip    = pk[k].dst;
        bus.src_udp_rx_udp_len   = 16'(pk[k].len);
        bus.src_udp_rx_timestamp = pk[k].ts;
    endtask

    task automatic drive_beat(input int k, input int i);
        logic [DW-1:0] d;
        int nb;
        nb = nbeats(k);
        for (int b = 0; b < 32; b++) begin
            d[DW-1-8*b -: 8] = (32*i + b < pk[k].len) ? pb[k][32*i + b] : 8'h00;
        end
        bus.src_udp_rx_data     = d;
        bus.src_udp_rx_data_val = 1'b1;
        bus.src_udp_rx_last     = (i == nb - 1);
        bus.src_udp_rx_padbytes = (i == nb - 1) ? 5'(32*nb - pk[k].len) : 5'd0;
    endtask

    // mode 0: sink always ready; 1: random sink and source gaps; 2: sink stalls cycles 3..5
    task automatic run(input int n, input int mode);
        int hdr_i = 0, dat_i = 0, beat_i = 0, done = 0, cyc = 0;
        bit in_pkt = 0, hdr_acc = 0, dat_acc = 0, out_acc = 0, last_seen = 0, hold = 0;
        bit prev_tval = 0, prev_trdy = 1;
        logic [DW-1:0] prev_data;
        logic [KW-1:0] prev_keep;
        logic          prev_last;
        line_t e;
        build_exp(n);
        bus.src_udp_rx_hdr_val  = 1'b0;
        bus.src_udp_rx_data_val = 1'b0;
        while (done < n) begin
            if (cyc >= 5000) begin
                check("run_timeout", 256'(done), 256'(n));
                break;
            end
            @(posedge clk); #1;
            if (hdr_acc) begin hdr_i++; in_pkt = 1; end
            if (dat_acc) begin
                beat_i++;
                if (beat_i == nbeats(dat_i)) begin dat_i++; beat_i = 0; end
            end
            if (out_acc && last_seen) begin in_pkt = 0; done++; end
            if (hdr_i < n) drive_hdr(hdr_i);
            else bus.src_udp_rx_hdr_val = 1'b0;
            hold = bus.src_udp_rx_data_val && !dat_acc;
            if (hold || ((dat_i < hdr_i) && (mode != 1 || $urandom_range(3) != 0)))
                drive_beat(dat_i, beat_i);
            else
                bus.src_udp_rx_data_val = 1'b0;
            case (mode)
                1:       bus.req_trdy = ($urandom_range(3) != 0);
                2:       bus.req_trdy = !(cyc >= 3 && cyc <= 5);
                default: bus.req_trdy = 1'b1;
            endcase
            @(negedge clk);
            check("hdr_rdy", 256'(bus.udp_rx_src_hdr_rdy), 256'(!in_pkt));
            if (!in_pkt) begin
                check("idle_tval", 256'(bus.req_tval), 256'(0));
                check("idle_data_rdy", 256'(bus.udp_rx_src_data_rdy), 256'(0));
            end else if (dat_i == done) begin
                check("pass_tval", 256'(bus.req_tval), 256'(bus.src_udp_rx_data_val));
                check("pass_data_rdy", 256'(bus.udp_rx_src_data_rdy), 256'(bus.req_trdy));
            end else begin
                check("flush_tval", 256'(bus.req_tval), 256'(1));
                check("flush_data_rdy", 256'(bus.udp_rx_src_data_rdy), 256'(0));
            end
            if (prev_tval && !prev_trdy) begin
                check("stall_tval", 256'(bus.req_tval), 256'(1));
                check("stall_tdata", bus.req_tdata, prev_data);
                check("stall_tkeep", 256'(bus.req_tkeep), 256'(prev_keep));
                check("stall_tlast", 256'(bus.req_tlast), 256'(prev_last));
            end
            out_acc   = bus.req_tval && bus.req_trdy;
            last_seen = 0;
            if (out_acc) begin
                if (expq.size() == 0) begin
                    check("extra_beat", 256'(bus.req_tval), 256'(0));
                end else begin
                    e = expq.pop_front();
                    check("tdata", bus.req_tdata, e.data);
                    check("tkeep", 256'(bus.req_tkeep), 256'(e.keep));
                    check("tlast", 256'(bus.req_tlast), 256'(e.last));
                    check("tuser", 256'(bus.req_tuser), 256'(e.user));
                    last_seen = e.last;
                end
            end
            hdr_acc   = bus.src_udp_rx_hdr_val && bus.udp_rx_src_hdr_rdy;
            dat_acc   = bus.src_udp_rx_data_val && bus.udp_rx_src_data_rdy;
            prev_tval = bus.req_tval;
            prev_trdy = bus.req_trdy;
            prev_data = bus.req_tdata;
            prev_keep = bus.req_tkeep;
            prev_last = bus.req_tlast;
            cyc++;
        end
        check("lines_left", 256'(expq.size()), 256'(0));
        @(posedge clk); #1;
        bus.src_udp_rx_hdr_val  = 1'b0;
        bus.src_udp_rx_data_val = 1'b0;
    endtask

    initial begin
        int dlen [7] = '{UDP_HDR_BYTES, 20, 21, 24, 32, 40, 52};
        rst                      = 1'b1;
        bus.src_udp_rx_hdr_val   = 1'b0;
        bus.src_udp_rx_src_ip    = '0;
        bus.src_udp_rx_dst_ip    = '0;
        bus.src_udp_rx_udp_len   = '0;
        bus.src_udp_rx_timestamp = '0;
        bus.src_udp_rx_data_val  = 1'b0;
        bus.src_udp_rx_data      = '0;
        bus.src_udp_rx_last      = 1'b0;
        bus.src_udp_rx_padbytes  = '0;
        bus.req_trdy             = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hdr_rdy", 256'(bus.udp_rx_src_hdr_rdy), 256'(1));
        check("rst_data_rdy", 256'(bus.udp_rx_src_data_rdy), 256'(0));
        check("rst_tval", 256'(bus.req_tval), 256'(0));

        // Boundary lengths: single line, r=20 exact, r=21 and r=32 spills, two-beat cases.
        for (int k = 0; k < 7; k++) make_pkt(k, dlen[k]);
        run(7, 0);

        // Sink stall in the middle of a four-beat packet.
        make_pkt(0, 120);
        run(1, 2);

        // Reset while in BODY drops the packet.
        make_pkt(0, 120);
        @(posedge clk); #1;
        drive_hdr(0);
        bus.req_trdy = 1'b1;
        @(posedge clk); #1;
        bus.src_udp_rx_hdr_val = 1'b0;
        drive_beat(0, 0);
        @(posedge clk); #1;
        drive_beat(0, 1);
        @(negedge clk);
        check("body_tval", 256'(bus.req_tval), 256'(1));
        check("body_hdr_rdy", 256'(bus.udp_rx_src_hdr_rdy), 256'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        drive_beat(0, 2);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tval", 256'(bus.req_tval), 256'(0));
        check("mid_rst_hdr_rdy", 256'(bus.udp_rx_src_hdr_rdy), 256'(1));
        check("mid_rst_data_rdy", 256'(bus.udp_rx_src_data_rdy), 256'(0));
        @(posedge clk); #1;
        bus.src_udp_rx_data_val = 1'b0;
        @(negedge clk);
        check("post_rst_tval", 256'(bus.req_tval), 256'(0));

        // Random lengths with random source gaps and sink backpressure.
        for (int k = 0; k < 20; k++) make_pkt(k, $urandom_range(UDP_HDR_BYTES, MAXB));
        run(20, 1);

        // Back-to-back packets with the header valid held high and the sink always ready.
        for (int k = 0; k < 4; k++) make_pkt(k, $urandom_range(UDP_HDR_BYTES, 100));
        run(4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
